aes_dec_iter: RTL
=================

AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 The parameter list SHALL contain: NR, default 10, number of cipher rounds; legal values are 10, 12 and 14, and the key store depth is NR+1.
REQ-002 The port list SHALL be, in order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- keyWrEn  in  1  round-key write strobe.
- keyWrAddr  in  4  round-key index, 0..NR.
- keyWrData  in  128  round-key value.
- inValid  in  1  ciphertext offered.
- inReady  out  1  block able to accept ciphertext.
- cipherText  in  128  input block.
- outValid  out  1  plaintext available.
- outReady  in  1  downstream accepts plaintext.
- plainText  out  128  result; MSB is byte 0.
- busy  out  1  high whenever the FSM is not in IDLE.
- keyErr  out  1  present only with AES_DEC_KEYGUARD_EN.

Function
REQ-003 The key store SHALL hold NR+1 128-bit words; a write stores keyWrData at keyWrAddr on the edge where keyWrEn=1.
REQ-004 A write with keyWrAddr > NR SHALL be ignored.
REQ-005 The FSM SHALL have four states: IDLE, ROUND, FINAL and DONE.
REQ-006 A handshake SHALL occur on any edge where inValid=1 and inReady=1.
REQ-007 inReady SHALL be 1 in IDLE, and in DONE while outReady=1; it SHALL be 0 otherwise.
REQ-008 On a handshake, the block SHALL load state <= cipherText XOR rk[NR], load cnt <= NR-1, and go to ROUND.
REQ-009 In ROUND, each edge SHALL apply InvShiftRows, then InvSubBytes, then XOR rk[cnt], then InvMixColumns, using the team's existing inverse-round stage; then cnt decrements.
REQ-010 The FSM SHALL leave ROUND for FINAL on the edge that processes cnt=1.
REQ-011 FINAL SHALL apply InvShiftRows, then InvSubBytes, then XOR rk[0], with no InvMixColumns; the FSM then goes to DONE and outValid=1.
REQ-012 Latency SHALL be NR edges from the accepting edge to outValid=1: 10 for NR=10, 14 for NR=14.
REQ-013 In DONE, outValid=1 and plainText SHALL be held stable until outValid=1 and outReady=1 on the same edge.
REQ-014 On that edge the FSM SHALL go to IDLE, unless inValid=1 as well, in which case it SHALL accept the new block directly into ROUND; this gives back-to-back operation with no bubble.
REQ-015 While busy, inValid SHALL be ignored; cipherText is sampled only at the handshake.
REQ-016 outValid SHALL never deassert without an output handshake, except under reset.
REQ-017 plainText SHALL equal the state register; its value outside DONE is don't-care for the consumer but deterministic.

Reset
REQ-018 Assertion of rst_n=0 SHALL take effect immediately, independent of clk.
REQ-019 During reset the FSM SHALL be in IDLE, cnt=0, state=0, and all key store words=0.
REQ-020 During reset the outputs SHALL be: outValid=0, busy=0, plainText=0, keyErr=0; inReady=0 while rst_n=0.
REQ-021 Reset mid-operation SHALL abort the block in flight, with no output handshake.
REQ-022 After deassertion, inReady=1 from the first clock edge onward.

Configuration
REQ-023 With macro AES_DEC_KEYGUARD_EN defined:
- key writes while busy=1 SHALL be discarded;
- each discarded write SHALL pulse keyErr high for one cycle, registered, on the edge after the write.
REQ-024 Without AES_DEC_KEYGUARD_EN:
- the keyErr port SHALL be absent;
- key writes SHALL always be accepted, and a write to the index in use takes effect from the next edge.

Verification
REQ-025 Decrypt one FIPS-197 C.1 block, NR=10:
- stimulus: load the round keys expanded from key 000102030405060708090a0b0c0d0e0f, with rk[10]=13111d7fe3944a17f307a78b4d2b30c5; then send cipherText=69c4e0d86a7b0430d8cdb78070b4c55a;
- response: plainText=00112233445566778899aabbccddeeff, with outValid high exactly 10 edges after acceptance.
REQ-026 Backpressure: hold outReady=0 for 20 cycles after outValid -> outValid stays 1, plainText is stable, and inReady=0 throughout.
REQ-027 Back-to-back: send the C.1 ciphertext twice with outReady=1 and inValid=1 held -> the second block is accepted on the edge the first is consumed, and the outputs arrive 10 edges apart.
REQ-028 Reset mid-run: pulse rst_n low at edge 5 of a decryption -> outValid, busy and plainText are 0 immediately; a fresh C.1 block then decrypts correctly after the keys are reloaded.
REQ-029 Keyguard, with the macro defined: write keyWrAddr=3 while busy -> keyErr pulses once, the key is unchanged, and C.1 still decrypts correctly.
REQ-030 Keyguard, with the macro not defined: write keyWrAddr=3 while busy -> the key is updated.

Source files
------------

// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES inverse cipher, one inverse round per clock.
// Round keys are written into an internal store of NR+1 words. A block is
// accepted through an inValid/inReady handshake and the plaintext is held on
// plainText with outValid until outReady is seen.
// Optional feature macro: AES_DEC_KEYGUARD_EN -- when defined, key writes
// while busy are dropped and reported on the keyErr pulse output.
module aes_dec_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         keyWrEn,
  input  logic [3:0]   keyWrAddr,
  input  logic [127:0] keyWrData,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] cipherText,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] plainText,
  output logic         busy
`ifdef AES_DEC_KEYGUARD_EN
  ,
  output logic         keyErr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } fsm_e;

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [3:0] CNT_INIT = 4'(NR - 1);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns constants 9, 11, 13, 14.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'd9:    return x8 ^ b;
      4'd11:   return x8 ^ x2 ^ b;
      4'd13:   return x8 ^ x4 ^ b;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  // Byte i of the state (column-major, byte 0 in the MSBs); row r of column c
  // moves right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q [0:NR];
  logic         key_we;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Shared inverse-round datapath; FINAL simply takes the result before mixing.
  assign shifted = inv_shift_rows(state_q);

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub
    assign subbed[8 * gi +: 8] = INV_SBOX[shifted[8 * gi +: 8]];
  end

  // cnt reaches 0 exactly when FINAL runs, so rk[cnt] also serves the last round.
  assign keyed = subbed ^ rk_q[cnt_q];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    localparam int HI = 127 - 32 * gi;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = keyed[HI -: 8];
    assign a1 = keyed[HI - 8 -: 8];
    assign a2 = keyed[HI - 16 -: 8];
    assign a3 = keyed[HI - 24 -: 8];
    assign mixed[HI -: 8]      = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
    assign mixed[HI - 8 -: 8]  = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
    assign mixed[HI - 16 -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
    assign mixed[HI - 24 -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
  end

  assign busy      = (fsm_q != S_IDLE);
  assign outValid  = (fsm_q == S_DONE);
  assign plainText = state_q;

`ifdef AES_DEC_KEYGUARD_EN
  logic key_err_q;

  assign key_we = keyWrEn && (keyWrAddr <= NR_L) && !busy;
  assign keyErr = key_err_q;

  // Flag every key write that arrives while a block is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_err_q <= 1'b0;
    end else begin
      key_err_q <= keyWrEn && busy;
    end
  end
`else
  assign key_we = keyWrEn && (keyWrAddr <= NR_L);
`endif

  // Round-key store; out-of-range indices never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else if (key_we) begin
      rk_q[keyWrAddr] <= keyWrData;
    end
  end

  // FSM, round counter and cipher state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next-state logic and input handshake; a DONE block may hand over straight to the next one.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    inReady = rst_n && ((fsm_q == S_IDLE) || ((fsm_q == S_DONE) && outReady));

    case (fsm_q)
      S_ROUND: begin
        state_d = mixed;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fsm_d = S_FINAL;
        end
      end
      S_FINAL: begin
        state_d = keyed;
        fsm_d   = S_DONE;
      end
      S_DONE: begin
        if (outReady) begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    if (inValid && inReady) begin
      state_d = cipherText ^ rk_q[NR];
      cnt_d   = CNT_INIT;
      fsm_d   = S_ROUND;
    end
  end

endmodule
